// File: rtl/tmds_frame_scheduler.sv
// One-lane TMDS raster sequencer: walks h/v timing and picks a pixel or DVI control symbol for the symbol FIFO.
// Optional underflow statistics counter is built when TMDS_SCHED_STATS_EN is defined.
module tmds_frame_scheduler #(
  parameter int          H_ACTIVE         = 640,
  parameter int          H_FRONT          = 16,
  parameter int          H_SYNC           = 96,
  parameter int          H_BACK           = 48,
  parameter int          V_ACTIVE         = 480,
  parameter int          V_FRONT          = 10,
  parameter int          V_SYNC           = 2,
  parameter int          V_BACK           = 33,
  parameter bit          SYNC_POL         = 1'b0,
  parameter bit          CTRL_FROM_SYNC   = 1'b1,
  parameter logic [9:0]  UNDERFLOW_SYMBOL = 10'b0100000000,
  localparam int         H_TOTAL          = H_ACTIVE + H_FRONT + H_SYNC + H_BACK,
  localparam int         V_TOTAL          = V_ACTIVE + V_FRONT + V_SYNC + V_BACK,
  localparam int         HW               = $clog2(H_TOTAL),
  localparam int         VW               = $clog2(V_TOTAL)
) (
  input  logic          clk_i,
  input  logic          reset_n_i,
  input  logic          enable_i,
  input  logic          symbol_fifo_full_i,
  output logic          write_symbol_o,
  output logic [9:0]    symbol_o,
  input  logic          pixel_valid_i,
  input  logic [9:0]    pixel_symbol_i,
  output logic          pixel_ready_o,
  output logic          hsync_o,
  output logic          vsync_o,
  output logic          de_o,
  output logic [HW-1:0] h_count_o,
  output logic [VW-1:0] v_count_o,
  output logic          frame_start_o,
  output logic          busy_o,
  output logic [15:0]   underflow_count_o
);

  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FRONT);
  localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FRONT);
  localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_e;

  state_e          state_q, state_d;
  logic [HW-1:0]   h_q, h_d;
  logic [VW-1:0]   v_q, v_d;
  logic            frame_last;
  logic [1:0]      ctrl;
  logic [9:0]      ctrl_sym;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      h_q     <= '0;
      v_q     <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
    end
  end

  // Output decode depends only on registered counters, so it is meaningful in IDLE as well.
  always_comb begin
    de_o           = (h_q < H_ACT) && (v_q < V_ACT);
    hsync_o        = ((h_q >= H_SS) && (h_q < H_SE)) ? SYNC_POL : ~SYNC_POL;
    vsync_o        = ((v_q >= V_SS) && (v_q < V_SE)) ? SYNC_POL : ~SYNC_POL;
    ctrl           = CTRL_FROM_SYNC ? {vsync_o, hsync_o} : 2'b00;
    case (ctrl)
      2'b00:   ctrl_sym = 10'b1101010100;
      2'b01:   ctrl_sym = 10'b0010101011;
      2'b10:   ctrl_sym = 10'b0101010100;
      default: ctrl_sym = 10'b1010101011;
    endcase
    symbol_o       = de_o ? (pixel_valid_i ? pixel_symbol_i : UNDERFLOW_SYMBOL) : ctrl_sym;
    busy_o         = (state_q != IDLE);
    write_symbol_o = busy_o && !symbol_fifo_full_i;
    pixel_ready_o  = write_symbol_o && de_o && pixel_valid_i;
    frame_start_o  = write_symbol_o && (h_q == '0) && (v_q == '0);
    frame_last     = (h_q == H_LAST) && (v_q == V_LAST);
    h_count_o      = h_q;
    v_count_o      = v_q;
  end

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (write_symbol_o) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  // A stopping frame always runs to its last symbol; re-enable wins over returning to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (enable_i) state_d = RUN;
      RUN:  if (!enable_i) state_d = (write_symbol_o && frame_last) ? IDLE : STOP;
      STOP: begin
        if (enable_i)                          state_d = RUN;
        else if (write_symbol_o && frame_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef TMDS_SCHED_STATS_EN
  logic [15:0] underflow_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      underflow_q <= '0;
    end else if (write_symbol_o && de_o && !pixel_valid_i && (underflow_q != 16'hFFFF)) begin
      underflow_q <= underflow_q + 16'd1;
    end
  end

  assign underflow_count_o = underflow_q;
`else
  assign underflow_count_o = 16'h0;
`endif

endmodule

// File: tb/tb_tmds_frame_scheduler.sv
// Directed bench for tmds_frame_scheduler on a tiny 8x6 raster (H 4/1/2/1, V 3/1/1/1, SYNC_POL=0).
module tb_tmds_frame_scheduler;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        full = 1'b0;
  logic        wr;
  logic [9:0]  sym;
  logic        valid = 1'b1;
  logic [9:0]  pix = 10'h2A5;
  logic        ready;
  logic        hs, vs, de;
  logic [2:0]  hc;
  logic [2:0]  vc;
  logic        fs;
  logic        busy;
  logic [15:0] ufc;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tmds_frame_scheduler #(
    .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .SYNC_POL(1'b0), .CTRL_FROM_SYNC(1'b1), .UNDERFLOW_SYMBOL(10'b0100000000)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n), .enable_i(enable), .symbol_fifo_full_i(full),
    .write_symbol_o(wr), .symbol_o(sym), .pixel_valid_i(valid), .pixel_symbol_i(pix),
    .pixel_ready_o(ready), .hsync_o(hs), .vsync_o(vs), .de_o(de),
    .h_count_o(hc), .v_count_o(vc), .frame_start_o(fs), .busy_o(busy),
    .underflow_count_o(ufc)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic advance_to(input int th, input int tv);
    int n = 0;
    #1;
    while (!(hc == 3'(th) && vc == 3'(tv)) && n < 200) begin
      step();
      #1;
      n++;
    end
    checks++;
    if (n >= 200) begin
      failures++;
      $display("FAIL advance_to(%0d,%0d) timeout: at h=%0d v=%0d", th, tv, hc, vc);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #2;
    checks++;
    if ({wr, busy, ready, fs} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ctl wr/busy/ready/fs=%b want 0000", {wr, busy, ready, fs});
    end
    checks++;
    if ({hc, vc} !== 6'd0 || {de, hs, vs} !== 3'b111) begin
      failures++;
      $display("FAIL reset_timing h=%0d v=%0d de/hs/vs=%b want 0 0 111", hc, vc, {de, hs, vs});
    end
    checks++;
    if (sym !== 10'h2A5) begin
      failures++;
      $display("FAIL reset_symbol got %b want %b", sym, 10'h2A5);
    end
    step();
    reset_n = 1'b1;
    enable  = 1'b1;
    #1;
    checks++;
    if (wr !== 1'b0) begin
      failures++;
      $display("FAIL idle_before_run wr=%b want 0", wr);
    end
    step();
    checks++;
    if ({wr, fs, ready, busy} !== 4'b1111 || sym !== 10'h2A5 || {hc, vc} !== 6'd0) begin
      failures++;
      $display("FAIL first_write wr/fs/ready/busy=%b sym=%b h=%0d v=%0d want 1111 %b 0 0",
               {wr, fs, ready, busy}, sym, hc, vc, 10'h2A5);
    end
  endtask

  task automatic test_free_run();
    logic [9:0] exp;
    int         writes = 0;
    for (int v = 0; v < 6; v++) begin
      for (int h = 0; h < 8; h++) begin
        pix = 10'h200 | 10'(h);
        #1;
        if (h < 4 && v < 3)                exp = 10'h200 | 10'(h);
        else if ((h == 5 || h == 6) && v == 4) exp = 10'b1101010100;
        else if (h == 5 || h == 6)         exp = 10'b0101010100;
        else if (v == 4)                   exp = 10'b0010101011;
        else                               exp = 10'b1010101011;
        checks++;
        if (hc !== 3'(h) || vc !== 3'(v) || sym !== exp || de !== (h < 4 && v < 3)) begin
          failures++;
          $display("FAIL free_run h=%0d v=%0d de=%b sym=%b want h=%0d v=%0d sym=%b", hc, vc, de, sym, h, v, exp);
        end
        checks++;
        if (hs !== !(h == 5 || h == 6) || vs !== (v != 4)) begin
          failures++;
          $display("FAIL free_run_sync at (%0d,%0d) hs=%b vs=%b", h, v, hs, vs);
        end
        if (wr) writes++;
        step();
      end
    end
    checks++;
    if (writes != 48 || {hc, vc} !== 6'd0 || fs !== 1'b1) begin
      failures++;
      $display("FAIL frame_wrap writes=%0d h=%0d v=%0d fs=%b want 48 0 0 1", writes, hc, vc, fs);
    end
  endtask

  task automatic test_backpressure();
    pix = 10'h155;
    step();
    step();
    full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (wr !== 1'b0 || ready !== 1'b0 || hc !== 3'd2 || sym !== 10'h155) begin
        failures++;
        $display("FAIL full_hold cyc%0d wr=%b ready=%b h=%0d sym=%b want 0 0 2 %b", i, wr, ready, hc, sym, 10'h155);
      end
      step();
    end
    full = 1'b0;
    #1;
    checks++;
    if (wr !== 1'b1 || ready !== 1'b1 || hc !== 3'd2 || sym !== 10'h155) begin
      failures++;
      $display("FAIL full_resume wr=%b ready=%b h=%0d sym=%b want 1 1 2 %b", wr, ready, hc, sym, 10'h155);
    end
    step();
    checks++;
    if (hc !== 3'd3) begin
      failures++;
      $display("FAIL full_advance h=%0d want 3", hc);
    end
  endtask

  task automatic test_underflow();
    advance_to(1, 0);
    valid = 1'b0;
    #1;
    checks++;
    if (sym !== 10'b0100000000 || ready !== 1'b0 || wr !== 1'b1) begin
      failures++;
      $display("FAIL underflow_sym sym=%b ready=%b wr=%b want 0100000000 0 1", sym, ready, wr);
    end
    step();
    valid = 1'b1;
    #1;
    checks++;
`ifdef TMDS_SCHED_STATS_EN
    if (ufc !== 16'd1) begin
      failures++;
      $display("FAIL underflow_count got %0d want 1", ufc);
    end
`else
    if (ufc !== 16'd0) begin
      failures++;
      $display("FAIL underflow_count got %0d want 0", ufc);
    end
`endif
  endtask

  task automatic test_stop();
    int n = 0;
    int lh = -1;
    int lv = -1;
    advance_to(0, 1);
    enable = 1'b0;
    #1;
    while (wr && n < 100) begin
      lh = int'(hc);
      lv = int'(vc);
      n++;
      step();
      #1;
    end
    checks++;
    if (n != 40 || lh != 7 || lv != 5) begin
      failures++;
      $display("FAIL stop_drain writes=%0d last=(%0d,%0d) want 40 (7,5)", n, lh, lv);
    end
    step();
    step();
    checks++;
    if (busy !== 1'b0 || wr !== 1'b0 || {hc, vc} !== 6'd0) begin
      failures++;
      $display("FAIL stop_idle busy=%b wr=%b h=%0d v=%0d want 0 0 0 0", busy, wr, hc, vc);
    end
    enable = 1'b1;
    step();
    advance_to(0, 2);
    enable = 1'b0;
    step();
    enable = 1'b1;
    advance_to(7, 5);
    step();
    checks++;
    if (busy !== 1'b1 || wr !== 1'b1 || fs !== 1'b1 || {hc, vc} !== 6'd0) begin
      failures++;
      $display("FAIL reenable_continue busy=%b wr=%b fs=%b h=%0d v=%0d want 1 1 1 0 0", busy, wr, fs, hc, vc);
    end
  endtask

  task automatic test_reset_midline();
    advance_to(3, 0);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({wr, busy, ready, fs} !== 4'b0000 || {hc, vc} !== 6'd0 || ufc !== 16'd0) begin
      failures++;
      $display("FAIL midline_reset wr/busy/ready/fs=%b h=%0d v=%0d ufc=%0d want 0000 0 0 0",
               {wr, busy, ready, fs}, hc, vc, ufc);
    end
    step();
    checks++;
    if (busy !== 1'b0 || wr !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold busy=%b wr=%b want 0 0", busy, wr);
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_backpressure();
    test_underflow();
    test_stop();
    test_reset_midline();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
